// File: rtl/serial_twos_comp_rx.sv
// Serial two's-complement receiver: LSB-first bit stream in, negated word out.
// Latency: word is presented the cycle after the edge sampling its last bit.
// Backpressure: holds data_ready/data_out until ack; ignores start/bits meanwhile.
// Optional even-parity bit per frame is built in when SERIAL_RX_PARITY_EN is defined.
module serial_twos_comp_rx #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             reset_b,
  input  logic             start,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready,
  output logic             busy,
  output logic             parity_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_PARITY, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic             f_q;
  logic [WIDTH-1:0] data_out_q;
  logic             data_ready_q;
  logic             busy_q;
  logic             out_bit_d;
  logic [WIDTH-1:0] sr_d;

`ifdef SERIAL_RX_PARITY_EN
  logic             acc_q;
  logic             parity_err_q;
`endif

  // Serial negation of the incoming bit and the resulting shifted word.
  always_comb begin
    out_bit_d = serial_in ^ f_q;
    sr_d      = {out_bit_d, sr_q[WIDTH-1:1]};
  end

  // Frame FSM with registered outputs; start aborts and restarts any frame in flight.
  always_ff @(posedge Clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      f_q          <= 1'b0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      acc_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RECV;
            busy_q  <= 1'b1;
            sr_q    <= '0;
            cnt_q   <= '0;
            f_q     <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            acc_q   <= 1'b0;
`endif
          end
        end

        S_RECV: begin
          if (start) begin
            sr_q  <= '0;
            cnt_q <= '0;
            f_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            acc_q <= 1'b0;
`endif
          end else if (bit_valid) begin
            sr_q  <= sr_d;
            f_q   <= f_q | serial_in;
            cnt_q <= cnt_q + 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            acc_q <= acc_q ^ serial_in;
            if (cnt_q == LAST_BIT) begin
              state_q <= S_PARITY;
            end
`else
            if (cnt_q == LAST_BIT) begin
              state_q      <= S_DONE;
              data_out_q   <= sr_d;
              data_ready_q <= 1'b1;
              busy_q       <= 1'b0;
            end
`endif
          end
        end

`ifdef SERIAL_RX_PARITY_EN
        S_PARITY: begin
          if (start) begin
            state_q <= S_RECV;
            sr_q    <= '0;
            cnt_q   <= '0;
            f_q     <= 1'b0;
            acc_q   <= 1'b0;
          end else if (bit_valid) begin
            state_q      <= S_DONE;
            data_out_q   <= sr_q;
            parity_err_q <= acc_q ^ serial_in;
            data_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
`endif

        S_DONE: begin
          if (ack) begin
            state_q      <= S_IDLE;
            data_ready_q <= 1'b0;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          data_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_ready = data_ready_q;
  assign busy       = busy_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/serial_twos_comp_rx.md
# serial_twos_comp_rx

Serial receiver for the two's-complement serial link: accepts a bit stream LSB-first, re-applies serial two's complement on the fly (copy up to and including the first 1, invert thereafter), and deserializes into a WIDTH-bit parallel word. Sits at the far end of the serial two's-complement transmitter and restores the original parallel value. Presents the word with a ready/ack handshake.

## Interface
- WIDTH, 8, data bits per frame (≥2)
- Clock  input  1  rising-edge clock
- reset_b  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a frame (IDLE or RECV)
- serial_in  input  1  serial data bit, LSB first
- bit_valid  input  1  qualifies serial_in for the current cycle
- ack  input  1  consumer acknowledge of data_out
- data_out  output  WIDTH  recovered word, stable while data_ready=1
- data_ready  output  1  word available; held until ack
- busy  output  1  high in RECV and PARITY states
- parity_err  output  1  parity mismatch for the word on data_out (0 when parity compiled out)

## Operation
- Reset value of every output: data_out=0, data_ready=0, busy=0, parity_err=0; state IDLE; shift register, bit counter, complement flag f, parity accumulator all 0.
- States: IDLE, RECV, PARITY (only with macro), DONE.
- IDLE: start=1 → RECV; clear count, f, shift register, parity accumulator. bit_valid ignored.
- RECV: on bit_valid=1: out_bit = serial_in ^ f; f <= f | serial_in; shift register <= {out_bit, sr[WIDTH-1:1]}; count++; parity accumulator ^= serial_in (raw received bit).
- Last data bit (count==WIDTH-1 with bit_valid): without macro → DONE, data_out <= final shifted word, data_ready <= 1. With macro → PARITY.
- PARITY: on bit_valid → DONE; data_out loaded; parity_err <= (acc ^ serial_in) != 0 (even parity over WIDTH raw bits + parity bit).
- DONE: data_ready=1, data_out held. ack=1 → IDLE, data_ready <= 0. start and bit_valid ignored in DONE (start in same cycle as ack also ignored).
- start during RECV/PARITY: abort, restart frame (counters/flag cleared), busy stays 1.
- data_out and parity_err keep last completed value through IDLE and the next RECV; change only on frame completion.
- Arithmetic: modulo 2^WIDTH; most-negative value (e.g. 8'h80) maps to itself; 0 maps to 0.
- Gaps: bit_valid=0 cycles inside RECV/PARITY stall with no state change; no timeout.

## Timing
- start sampled at edge k → busy=1 after edge k; first bit may be sampled at edge k+1.
- Data word ready after the edge sampling the last bit (data) or parity bit: data_ready=1 in the following cycle, zero extra latency. Minimum frame: 1 + WIDTH cycles (+1 with parity).
- ack sampled at edge m → data_ready=0 after edge m; next start accepted at edge m+1.
- reset_b low at any time: immediate return to reset values regardless of state; frame in progress lost.

## Configuration
- SERIAL_RX_PARITY_EN defined: frame = WIDTH data bits + 1 even-parity bit; PARITY state present; parity_err computed per frame.
- Not defined: frame = WIDTH bits; PARITY state absent; parity_err tied 0; port list unchanged.

## Test plan
- Reset: assert reset_b=0 mid-RECV after 3 bits → all outputs 0, state IDLE; new frame then completes normally.
- Basic decode: start, bits 1,1,0,1,1,1,1,1 (stream 8'hFB) with bit_valid every cycle → data_out=8'h05, data_ready=1 one cycle after 8th bit; held until ack.
- Boundaries: streams 8'h00 → 8'h00, 8'hFF → 8'h01, 8'h80 → 8'h80; bit_valid gaps of 1–3 cycles between bits give same results.
- Handshake: hold ack=0 10 cycles with start pulses and bit_valid → data_out unchanged, no new frame; ack+start same cycle → IDLE, start ignored.
- Abort: start, 4 bits, start again, 8 bits of 8'hFB → data_out=8'h05 (first partial frame discarded).
- SERIAL_RX_PARITY_EN: 8'hFB + parity bit 1 → data_out=8'h05, parity_err=0; parity bit 0 → parity_err=1; macro off → parity_err always 0.
